// File: rtl/syscall_ctrl.sv
// Syscall service controller: print-hex with display handshake and hold, halt, and bad-code reporting.
// The CPU stalls while a print or halt is in progress. Every retired syscall pulses sys_ack.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for syscall_req; unknown codes retire here directly
// OUT_WAIT | print argument offered on out_valid, waiting for out_ready
// HOLD     | display hold countdown before the print retires
// HALTED   | CPU halted; only reset leaves this state
module syscall_ctrl #(
    parameter logic [7:0]  PRINT_CODE  = 8'd1,
    parameter logic [7:0]  HALT_CODE   = 8'd10,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall_req,
    input  logic [7:0]  v0,
    input  logic [31:0] a0,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] hex_out,
    output logic        stall,
    output logic        sys_ack,
    output logic        halt,
    output logic        bad_code,
    output logic [15:0] sys_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_WAIT = 2'd1,
        HOLD     = 2'd2,
        HALTED   = 2'd3
    } state_e;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] arg_q, arg_d;
    logic [31:0] hex_q, hex_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        bad_q, bad_d;
    logic [15:0] count_q, count_d;

    logic is_print;
    logic is_halt;

    // Print is decoded first so it wins when both codes are equal.
    assign is_print = (v0 == PRINT_CODE);
    assign is_halt  = (v0 == HALT_CODE) && !is_print;

    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        hex_d   = hex_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (syscall_req) begin
                    if (is_print) begin
                        arg_d   = a0;
                        state_d = OUT_WAIT;
                    end else if (is_halt) begin
                        ack_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        ack_d = 1'b1;
                        bad_d = 1'b1;
                    end
                end
            end
            OUT_WAIT: begin
                if (out_ready) begin
                    hex_d   = arg_q;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        count_d = count_q;
        if (ack_d && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            arg_q   <= 32'd0;
            hex_q   <= 32'd0;
            cnt_q   <= 8'd0;
            ack_q   <= 1'b0;
            bad_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            bad_q   <= bad_d;
            count_q <= count_d;
        end
    end

    // The request cycle must already freeze the PC, so stall looks at the inputs while IDLE.
    assign stall = rst_n && ((state_q != IDLE) || (syscall_req && (is_print || is_halt)));

    assign out_valid = (state_q == OUT_WAIT);
    assign halt      = (state_q == HALTED);
    assign hex_out   = hex_q;
    assign sys_ack   = ack_q;
    assign bad_code  = bad_q;
    assign sys_count = count_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl: a per-cycle vector table plus hand sequences for
// backpressure, code precedence, reset mid-hold, halt and count saturation.
module tb_syscall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        syscall_req;
    logic [7:0]  v0;
    logic [31:0] a0;
    logic        out_ready;

    logic        out_valid, stall, sys_ack, halt, bad_code;
    logic [31:0] hex_out;
    logic [15:0] sys_count;

    logic        s2_valid, s2_stall, s2_ack, s2_halt, s2_bad;
    logic [31:0] s2_hex;
    logic [15:0] s2_count;

    int n_vec = 0;
    int n_err = 0;

    syscall_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .syscall_req(syscall_req), .v0(v0), .a0(a0),
        .out_ready(out_ready), .out_valid(out_valid), .hex_out(hex_out), .stall(stall),
        .sys_ack(sys_ack), .halt(halt), .bad_code(bad_code), .sys_count(sys_count)
    );

    // Shared print/halt code with the shortest hold.
    syscall_ctrl #(.PRINT_CODE(8'd5), .HALT_CODE(8'd5), .HOLD_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .syscall_req(syscall_req), .v0(v0), .a0(a0),
        .out_ready(out_ready), .out_valid(s2_valid), .hex_out(s2_hex), .stall(s2_stall),
        .sys_ack(s2_ack), .halt(s2_halt), .bad_code(s2_bad), .sys_count(s2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [7:0]  code;
        logic [31:0] arg;
        logic        rdy;
        logic        e_stall;
        logic        e_valid;
        logic        e_ack;
        logic        e_bad;
        logic        e_halt;
        logic [31:0] e_hex;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t vt[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic rq, input logic [7:0] c, input logic [31:0] ar,
                        input logic rd, input logic es, input logic ev, input logic ea,
                        input logic eb, input logic eh, input logic [31:0] ex, input logic [15:0] ec);
        vt[i] = '{rq, c, ar, rd, es, ev, ea, eb, eh, ex, ec};
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ack"}, 32'(sys_ack), 32'd0);
        chk({tag, "_bad"}, 32'(bad_code), 32'd0);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
        chk({tag, "_hex"}, hex_out, 32'd0);
        chk({tag, "_count"}, 32'(sys_count), 32'd0);
        chk({tag, "_stall2"}, 32'(s2_stall), 32'd0);
    endtask

    // One syscall issued in cycle 0, then a fixed 24-cycle window; out_ready is low for
    // the first ready_delay OUT_WAIT cycles. Counts are taken at the falling edge.
    task automatic measure(input logic [7:0] code, input logic [31:0] arg, input int ready_delay,
                           output int st_n, output int va_n, output int ak_n,
                           output int st2_n, output int va2_n, output int ak2_n);
        logic [31:0] hex_before;
        hex_before = hex_out;
        st_n = 0; va_n = 0; ak_n = 0; st2_n = 0; va2_n = 0; ak2_n = 0;
        for (int k = 0; k < 24; k++) begin
            syscall_req = (k == 0);
            v0          = (k == 0) ? code : 8'd0;
            a0          = (k == 0) ? arg : 32'hFFFF_FFFF;
            out_ready   = (k > ready_delay);
            @(negedge clk);
            st_n  += int'(stall);
            va_n  += int'(out_valid);
            ak_n  += int'(sys_ack);
            st2_n += int'(s2_stall);
            va2_n += int'(s2_valid);
            ak2_n += int'(s2_ack);
            if (out_valid) chk("hold_hex_before_accept", hex_out, hex_before);
            @(posedge clk); #1;
        end
        syscall_req = 1'b0;
    endtask

    initial begin
        int st_n, va_n, ak_n, st2_n, va2_n, ak2_n, cnt;

        //   i  req code  arg           rdy  stall valid ack bad halt hex           count
        setv(0,  1, 8'd1, 32'hDEADBEEF, 1,   1,    0,    0,  0,  0,   32'h0,        16'd0);
        setv(1,  1, 8'd7, 32'h12345678, 1,   1,    1,    0,  0,  0,   32'h0,        16'd0);
        setv(2,  1, 8'd7, 32'h12345678, 1,   1,    0,    0,  0,  0,   32'hDEADBEEF, 16'd0);
        setv(3,  1, 8'd7, 32'h12345678, 1,   1,    0,    0,  0,  0,   32'hDEADBEEF, 16'd0);
        setv(4,  1, 8'd7, 32'h12345678, 1,   1,    0,    0,  0,  0,   32'hDEADBEEF, 16'd0);
        setv(5,  1, 8'd7, 32'h12345678, 1,   1,    0,    0,  0,  0,   32'hDEADBEEF, 16'd0);
        setv(6,  0, 8'd0, 32'h0,        1,   0,    0,    1,  0,  0,   32'hDEADBEEF, 16'd1);
        setv(7,  1, 8'd7, 32'h0,        1,   0,    0,    0,  0,  0,   32'hDEADBEEF, 16'd1);
        setv(8,  0, 8'd0, 32'h0,        1,   0,    0,    1,  1,  0,   32'hDEADBEEF, 16'd2);
        setv(9,  0, 8'd0, 32'h0,        1,   0,    0,    0,  0,  0,   32'hDEADBEEF, 16'd2);
        setv(10, 1, 8'd1, 32'hCAFEF00D, 0,   1,    0,    0,  0,  0,   32'hDEADBEEF, 16'd2);
        setv(11, 0, 8'd0, 32'h0,        0,   1,    1,    0,  0,  0,   32'hDEADBEEF, 16'd2);
        setv(12, 0, 8'd0, 32'h0,        0,   1,    1,    0,  0,  0,   32'hDEADBEEF, 16'd2);
        setv(13, 0, 8'd0, 32'h0,        1,   1,    1,    0,  0,  0,   32'hDEADBEEF, 16'd2);
        setv(14, 0, 8'd0, 32'h0,        1,   1,    0,    0,  0,  0,   32'hCAFEF00D, 16'd2);
        setv(15, 0, 8'd0, 32'h0,        1,   1,    0,    0,  0,  0,   32'hCAFEF00D, 16'd2);
        setv(16, 0, 8'd0, 32'h0,        1,   1,    0,    0,  0,  0,   32'hCAFEF00D, 16'd2);
        setv(17, 0, 8'd0, 32'h0,        1,   1,    0,    0,  0,  0,   32'hCAFEF00D, 16'd2);
        setv(18, 1, 8'd7, 32'h0,        1,   0,    0,    1,  0,  0,   32'hCAFEF00D, 16'd3);
        setv(19, 1, 8'd7, 32'h0,        1,   0,    0,    1,  1,  0,   32'hCAFEF00D, 16'd4);
        setv(20, 0, 8'd0, 32'h0,        1,   0,    0,    1,  1,  0,   32'hCAFEF00D, 16'd5);
        setv(21, 0, 8'd0, 32'h0,        1,   0,    0,    0,  0,  0,   32'hCAFEF00D, 16'd5);

        // Reset state, with a print request present to show stall is held low.
        rst_n = 1'b0; syscall_req = 1'b1; v0 = 8'd1; a0 = 32'h1; out_ready = 1'b1;
        #13;
        check_all_zero("reset");
        syscall_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            syscall_req = vt[i].req;
            v0          = vt[i].code;
            a0          = vt[i].arg;
            out_ready   = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_ack", i), 32'(sys_ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d_bad", i), 32'(bad_code), 32'(vt[i].e_bad));
            chk($sformatf("v%0d_halt", i), 32'(halt), 32'(vt[i].e_halt));
            chk($sformatf("v%0d_hex", i), hex_out, vt[i].e_hex);
            chk($sformatf("v%0d_count", i), 32'(sys_count), 32'(vt[i].e_cnt));
            @(posedge clk); #1;
        end

        // Backpressure: ten cycles without out_ready.
        measure(8'd1, 32'h11223344, 10, st_n, va_n, ak_n, st2_n, va2_n, ak2_n);
        chk("bp_stall_cycles", 32'(st_n), 32'd16);
        chk("bp_valid_cycles", 32'(va_n), 32'd11);
        chk("bp_ack_count", 32'(ak_n), 32'd1);
        chk("bp_hex", hex_out, 32'h11223344);
        chk("bp_sys_count", 32'(sys_count), 32'd6);

        // Print code equal to halt code: print wins; HOLD_CYCLES=1 gives 3 stall cycles.
        measure(8'd5, 32'h0BADF00D, 0, st_n, va_n, ak_n, st2_n, va2_n, ak2_n);
        chk("prec_dut1_stall", 32'(st_n), 32'd0);
        chk("prec_dut1_ack", 32'(ak_n), 32'd1);
        chk("prec_dut1_count", 32'(sys_count), 32'd7);
        chk("prec_stall", 32'(st2_n), 32'd3);
        chk("prec_valid", 32'(va2_n), 32'd1);
        chk("prec_ack", 32'(ak2_n), 32'd1);
        chk("prec_halt", 32'(s2_halt), 32'd0);
        chk("prec_hex", s2_hex, 32'h0BADF00D);

        // Reset asserted during the second HOLD cycle.
        syscall_req = 1'b1; v0 = 8'd1; a0 = 32'h55AA55AA; out_ready = 1'b1;
        @(posedge clk); #1;
        syscall_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rh_pre_stall", 32'(stall), 32'd1);
        chk("rh_pre_hex", hex_out, 32'h55AA55AA);
        rst_n = 1'b0;
        #1;
        check_all_zero("rh");
        @(negedge clk); rst_n = 1'b1;
        ak_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ak_n += int'(sys_ack);
        end
        chk("rh_no_ack", 32'(ak_n), 32'd0);
        @(posedge clk); #1;

        measure(8'd1, 32'hA5A5A5A5, 0, st_n, va_n, ak_n, st2_n, va2_n, ak2_n);
        chk("post_rst_stall", 32'(st_n), 32'd6);
        chk("post_rst_valid", 32'(va_n), 32'd1);
        chk("post_rst_ack", 32'(ak_n), 32'd1);
        chk("post_rst_hex", hex_out, 32'hA5A5A5A5);
        chk("post_rst_count", 32'(sys_count), 32'd1);

        // Halt, then keep requesting prints which must be ignored.
        st_n = 0; va_n = 0; ak_n = 0; cnt = 0;
        for (int k = 0; k < 21; k++) begin
            syscall_req = 1'b1;
            v0          = (k == 0) ? 8'd10 : 8'd1;
            a0          = 32'h77777777;
            out_ready   = 1'b1;
            @(negedge clk);
            st_n += int'(stall);
            va_n += int'(out_valid);
            ak_n += int'(sys_ack);
            cnt  += int'(halt);
            @(posedge clk); #1;
        end
        chk("halt_stall_cycles", 32'(st_n), 32'd21);
        chk("halt_halt_cycles", 32'(cnt), 32'd20);
        chk("halt_valid_cycles", 32'(va_n), 32'd0);
        chk("halt_ack_count", 32'(ak_n), 32'd1);
        chk("halt_hex", hex_out, 32'hA5A5A5A5);
        chk("halt_count", 32'(sys_count), 32'd2);

        // Saturation: one bad-code syscall retires every cycle while the request is held.
        rst_n = 1'b0; syscall_req = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        syscall_req = 1'b1; v0 = 8'd7; a0 = 32'h0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", 32'(sys_count), 32'h0000FFFE);
        repeat (10) @(posedge clk);
        #1;
        chk("sat_hold", 32'(sys_count), 32'h0000FFFF);
        chk("sat_bad", 32'(bad_code), 32'd1);
        chk("sat_stall", 32'(stall), 32'd0);
        syscall_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
